// File: rtl/tl_pkg.sv
// tl_pkg: shared phase, mode and 7-segment definitions for the traffic-light controller
package tl_pkg;
    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, FLASH} phase_t;
    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_FLASH  = 2'b10;
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: decimal digit to active-low abcdefg segments with blanking
module seg7_decode
    import tl_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = (blank || digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: round-robin N-lane light sequencer with clearance, countdown, manual and flash modes
module traffic_light_ctrl_n
    import tl_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int TICK_DIV    = 50_000_000,
    parameter int TIME_GREEN  = 15,
    parameter int TIME_YELLOW = 3,
    parameter int TIME_ALLRED = 1,
    localparam int LW = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 manual_next,
    output logic [NUM_LANES-1:0] red,
    output logic [NUM_LANES-1:0] yellow,
    output logic [NUM_LANES-1:0] green,
    output logic [LW-1:0]        active_lane,
    output logic [6:0]           seg_tens,
    output logic [6:0]           seg_ones
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    phase_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d, next_lane;
    logic [6:0]           rem_q, rem_d;
    logic                 blink_q, blink_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic                 tick;
    logic [NUM_LANES-1:0] onehot;
    logic [3:0]           tens, ones;

    assign tick      = pre_q == PW'(TICK_DIV - 1);
    assign next_lane = (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        if (mode >= MODE_FLASH) begin
            state_d = FLASH;
            blink_d = (state_q != FLASH) | (blink_q ^ tick);
        end else if (state_q == FLASH) begin
            // parking on the last lane makes the following ALLRED->GREEN step land on lane 0
            state_d = ALLRED;
            rem_d   = 7'(TIME_ALLRED);
            lane_d  = LW'(NUM_LANES - 1);
        end else if (state_q == GREEN && mode == MODE_MANUAL) begin
            state_d = manual_next ? YELLOW : state_q;
            rem_d   = manual_next ? 7'(TIME_YELLOW) : rem_q;
        end else if (tick) begin
            state_d = (rem_q != 7'd1) ? state_q : (state_q == GREEN) ? YELLOW : (state_q == YELLOW) ? ALLRED : GREEN;
            rem_d   = (rem_q != 7'd1) ? rem_q - 1'b1 : (state_q == GREEN) ? 7'(TIME_YELLOW) :
                      (state_q == YELLOW) ? 7'(TIME_ALLRED) : 7'(TIME_GREEN);
            lane_d  = (rem_q == 7'd1 && state_q == ALLRED) ? next_lane : lane_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GREEN;
            lane_q  <= '0;
            rem_q   <= 7'(TIME_GREEN);
            blink_q <= 1'b0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            blink_q <= blink_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        onehot      = NUM_LANES'(1) << lane_q;
        green       = (state_q == GREEN) ? onehot : '0;
        yellow      = (state_q == YELLOW) ? onehot : (state_q == FLASH) ? {NUM_LANES{blink_q}} : '0;
        red         = (state_q == ALLRED) ? '1 : (state_q == FLASH) ? '0 : ~onehot;
        active_lane = lane_q;
        tens        = 4'(rem_q / 7'd10);
        ones        = 4'(rem_q % 7'd10);
    end

    seg7_decode u_tens (.digit(tens), .blank(state_q == FLASH), .seg(seg_tens));
    seg7_decode u_ones (.digit(ones), .blank(state_q == FLASH), .seg(seg_ones));
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: scoreboard bench comparing two prescaler variants against a phase-table model
module tb_traffic_light_ctrl_n;
    localparam int NL = 3;
    localparam int TG = 15, TY = 3, TA = 1;

    typedef struct packed {
        logic [NL-1:0] r, y, g;
        logic [1:0]    lane;
        logic          chk_lane;
        logic [6:0]    t, o;
    } exp_t;

    logic clk = 0, reset = 1, manual_next = 0;
    logic [1:0] mode = 0;
    logic [NL-1:0] red0, yellow0, green0, red1, yellow1, green1;
    logic [1:0] al0, al1;
    logic [6:0] st0, so0, st1, so1;
    int checks = 0, passed = 0;
    exp_t q0[$], q1[$];
    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int dur[3] = '{TG, TY, TA};
    int td[2] = '{1, 4};
    int ph[2] = '{0, 0}, ln[2] = '{0, 0}, rem[2] = '{TG, TG}, pre[2] = '{0, 0};
    int blink[2] = '{0, 0}, restart[2] = '{0, 0};

    always #5 clk = ~clk;

    traffic_light_ctrl_n #(.NUM_LANES(NL), .TICK_DIV(1), .TIME_GREEN(TG), .TIME_YELLOW(TY), .TIME_ALLRED(TA)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .manual_next(manual_next), .red(red0), .yellow(yellow0),
        .green(green0), .active_lane(al0), .seg_tens(st0), .seg_ones(so0));
    traffic_light_ctrl_n #(.NUM_LANES(NL), .TICK_DIV(4), .TIME_GREEN(TG), .TIME_YELLOW(TY), .TIME_ALLRED(TA)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .manual_next(manual_next), .red(red1), .yellow(yellow1),
        .green(green1), .active_lane(al1), .seg_tens(st1), .seg_ones(so1));

    // phases: 0 green, 1 yellow, 2 all-red, 3 flash
    task automatic step(input int k, input bit rst, input int md, input bit mn);
        bit tick = (pre[k] == td[k] - 1);
        if (rst) begin
            ph[k] = 0; ln[k] = 0; rem[k] = TG; pre[k] = 0; blink[k] = 0; restart[k] = 0;
            return;
        end
        pre[k] = (pre[k] + 1) % td[k];
        if (md >= 2) begin
            blink[k] = (ph[k] != 3) ? 1 : (tick ? 1 - blink[k] : blink[k]);
            ph[k] = 3;
        end else if (ph[k] == 3) begin
            ph[k] = 2; rem[k] = TA; restart[k] = 1;
        end else if (ph[k] == 0 && md == 1) begin
            if (mn) begin ph[k] = 1; rem[k] = TY; end
        end else if (tick) begin
            if (rem[k] > 1) rem[k]--;
            else begin
                ph[k] = (ph[k] + 1) % 3;
                rem[k] = dur[ph[k]];
                if (ph[k] == 0) begin
                    ln[k] = restart[k] ? 0 : (ln[k] + 1) % NL;
                    restart[k] = 0;
                end
            end
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e = '0;
        for (int i = 0; i < NL; i++) begin
            if (ph[k] == 3) e.y[i] = blink[k][0];
            else if (ph[k] == 2 || i != ln[k]) e.r[i] = 1;
            else if (ph[k] == 0) e.g[i] = 1;
            else e.y[i] = 1;
        end
        e.lane = 2'(ln[k]);
        e.chk_lane = ph[k] < 2;
        e.t = (ph[k] == 3) ? 7'h7F : seg_tbl[rem[k] / 10];
        e.o = (ph[k] == 3) ? 7'h7F : seg_tbl[rem[k] % 10];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    endtask

    task automatic cyc(input bit rst, input int md, input bit mn);
        @(negedge clk);
        reset = rst; mode = 2'(md); manual_next = mn;
        step(0, rst, md, mn);
        step(1, rst, md, mn);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    task automatic run(input int n, input int md, input int mn_pct, input int rst_pct);
        for (int i = 0; i < n; i++)
            cyc($urandom_range(99) < rst_pct, md, $urandom_range(99) < mn_pct);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("div1_red", red0, e.r); chk("div1_yellow", yellow0, e.y); chk("div1_green", green0, e.g);
                if (e.chk_lane) chk("div1_lane", al0, e.lane);
                chk("div1_tens", st0, e.t); chk("div1_ones", so0, e.o);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("div4_red", red1, e.r); chk("div4_yellow", yellow1, e.y); chk("div4_green", green1, e.g);
                if (e.chk_lane) chk("div4_lane", al1, e.lane);
                chk("div4_tens", st1, e.t); chk("div4_ones", so1, e.o);
            end
        end
    end

    initial begin
        run(3, 0, 0, 100);
        run(70, 0, 0, 0);
        run(40, 0, 30, 0);
        run(120, 1, 0, 0);
        cyc(0, 1, 1);
        run(30, 1, 0, 0);
        run(200, 1, 10, 0);
        run(25, 0, 0, 0);
        run(12, 2, 20, 0);
        run(40, 0, 0, 0);
        run(9, 3, 0, 0);
        run(30, 1, 0, 0);
        run(17, 0, 0, 0);
        cyc(1, 0, 0);
        run(20, 0, 0, 0);
        repeat (150) run($urandom_range(1, 40), $urandom_range(0, 99) < 50 ? 0 : $urandom_range(1, 3), 12, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL queue_drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl_n.md
# traffic_light_ctrl_n

- Parametrised N-lane traffic-light controller: generalises the two-lane auto sequencer to NUM_LANES approaches served round-robin.
- Adds an all-red clearance phase, an internal seconds prescaler, a countdown display of remaining phase time, manual step mode and a night flash mode.
- Sits between the board clock/reset and the lamp drivers and 7-segment digits of the intersection.

## Interface
- NUM_LANES, 2, number of approaches (2..8).
- TICK_DIV, 50_000_000, clk cycles per one-second tick (≥1; 1 = tick every cycle).
- TIME_GREEN, 15, green duration in ticks (1..99).
- TIME_YELLOW, 3, yellow duration in ticks (1..99).
- TIME_ALLRED, 1, all-red clearance in ticks (1..99).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  00 auto, 01 manual, 10 flash, 11 treated as flash.
- manual_next  in  1  single-cycle request to advance; honoured only in manual mode, GREEN phase.
- red  out  NUM_LANES  red lamp per lane.
- yellow  out  NUM_LANES  yellow lamp per lane.
- green  out  NUM_LANES  green lamp per lane.
- active_lane  out  LW=max(1,$clog2(NUM_LANES))  lane owning the current GREEN/YELLOW phase.
- seg_tens  out  7  active-low abcdefg digit, tens of remaining ticks.
- seg_ones  out  7  active-low abcdefg digit, ones of remaining ticks.

## Operation
- Phase FSM states: GREEN, YELLOW, ALLRED, FLASH. Registers: state, active_lane, rem (7 bits), blink, prescaler.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 when the count equals TICK_DIV-1. Free-running; cleared only by reset.
- Entering a phase loads rem with that phase's time.
- On a tick in auto mode: if rem==1, advance; else rem decrements.
- Sequence: GREEN → YELLOW → ALLRED → GREEN of active_lane+1. active_lane increments on the ALLRED→GREEN transition and wraps from NUM_LANES-1 to 0.
- Manual mode, GREEN: rem frozen and ticks ignored. manual_next moves to YELLOW. YELLOW and ALLRED then run timed as in auto, and the next lane's GREEN holds again.
- Manual mode, YELLOW or ALLRED: timed as in auto.
- Switching manual→auto during GREEN resumes the countdown from the frozen rem.
- Flash mode: entered immediately from any state on the cycle mode≥10 is sampled. Entry sets blink=1, and blink toggles on every tick.
- Leaving flash (mode<10): go to ALLRED with TIME_ALLRED, then GREEN with active_lane=0.
- Lamps are a pure decode of registered state:
  - GREEN: green[active_lane]=1, all other red=1.
  - YELLOW: yellow[active_lane]=1, all other red=1.
  - ALLRED: red all 1.
  - FLASH: yellow all = blink; red and green 0.
- Exactly one lamp per lane is lit, except in FLASH.
- Display: rem split into tens=rem/10 and ones=rem%10, each encoded with 0=0000001 … 9=0000100. FLASH blanks both digits (1111111).

## Timing
- Reset values:
  - state=GREEN, active_lane=0, rem=TIME_GREEN, prescaler=0, blink=0.
  - green=…0001, red=~…0001, yellow=0.
  - Digits show TIME_GREEN.
- Reset mid-operation restores these values at the next edge, overriding all other inputs.
- Latency: phase/rem change is registered on the edge where tick=1 and visible on outputs in the same cycle as the new register value. No extra pipeline stage.
- Full auto cycle per lane = TIME_GREEN+TIME_YELLOW+TIME_ALLRED ticks. Display shows T..1 in each phase; 0 is never shown.
- Simultaneous events:
  - Flash request beats tick and manual_next.
  - manual_next together with tick in manual GREEN goes to YELLOW with rem=TIME_YELLOW.
  - manual_next in any other state or mode is dropped, never queued.

## Structure
- Shared package tl_pkg holds:
  - the phase enum (GREEN, YELLOW, ALLRED, FLASH);
  - mode codes (MODE_AUTO, MODE_MANUAL, MODE_FLASH);
  - SEG_BLANK and the digit-to-7-segment constant table.
- One sub-module, seg7_decode: 4-bit digit plus blank input to 7-bit active-low segments, instantiated twice.
- The prescaler stays inline.

## Test plan
All scenarios use TICK_DIV=1, NUM_LANES=3, 15/3/1 timing.
- Reset release, auto:
  - Lane 0 green for 15 cycles, digits 15..1, then yellow 3, then all-red 1, then lane 1 green.
  - After 57 cycles lane 0 is green again (wrap from lane 2).
- Manual mode: GREEN holds rem=15 for 100 cycles. Pulse manual_next → next cycle yellow[0], rem=3; 4 cycles later green[1] holds.
- manual_next in auto or during YELLOW → no effect on the phase sequence.
- mode=10 during lane 1 GREEN:
  - Next cycle all yellow on, red/green 0, digits blank; yellow toggles every cycle.
  - mode=00 → 1 cycle all-red, then green[0] with rem=15.
- Reset asserted mid-YELLOW on lane 2 → next edge matches all reset values.
- TICK_DIV=4: rem decrements exactly every 4th cycle; prescaler unaffected by mode changes.
